// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD (shift-add-3) converter feeding a 4-digit time-multiplexed display scanner.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_BLANK_LEADING_ZEROS_EN.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [3:0]  an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RCNT_MAX = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic [11:0]   bcd_adj;
  logic [13:0]   value_clamped;
  logic [RW-1:0] rcnt_q;
  logic [1:0]    idx_q;

  assign value_clamped = (value > 14'd9999) ? 14'd9999 : value;

  // The input is clamped to 9999, so the thousands nibble is at most 4 before
  // any shift and never needs the add-3 correction; only the lower three do.
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                            : bcd_q[4*gi +: 4];
  end

  // State register and converter datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (cnt_q == 4'd13) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d = value_clamped;
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      CONV: begin
        bcd_d = {bcd_q[14:12], bcd_adj, bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      COMMIT:  disp_d = bcd_q;
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else if (rcnt_q == RCNT_MAX) begin
      rcnt_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      rcnt_q <= rcnt_q + 1'b1;
    end
  end

`ifdef BCD_SCAN_BLANK_LEADING_ZEROS_EN
  logic [3:0] blank_q, blank_d;

  // A digit blanks when it and every higher digit are zero; units never blanks.
  always_comb begin
    blank_d = blank_q;
    if (state_q == COMMIT) begin
      blank_d[3] = (bcd_q[15:12] == 4'd0);
      blank_d[2] = blank_d[3] && (bcd_q[11:8] == 4'd0);
      blank_d[1] = blank_d[2] && (bcd_q[7:4] == 4'd0);
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end

  always_comb begin
    digit = blank_q[idx_q] ? 4'hF : disp_q[{idx_q, 2'b00} +: 4];
    an    = 4'b0001 << idx_q;
  end
`else
  always_comb begin
    digit = disp_q[{idx_q, 2'b00} +: 4];
    an    = 4'b0001 << idx_q;
  end
`endif

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: directed and random loads checked
// against a decimal-arithmetic model of the displayed digits and scan position.
module tb_bcd_display_scanner;

  localparam int DIV = 2;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic [3:0]  digit;
  logic [3:0]  an;

  int checks;
  int failures;
  int k;          // clock edges since reset released
  int exp_val;    // value currently committed to the display
  bit exp_busy;

  bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .digit (digit),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampv(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [3:0] exp_digit(int val, int i);
    int p [4];
    int d;
    p = '{1, 10, 100, 1000};
    d = (val / p[i]) % 10;
`ifdef BCD_SCAN_BLANK_LEADING_ZEROS_EN
    if (i > 0 && val < p[i]) return 4'hF;
`endif
    return 4'(d);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) k = 0;
    else     k++;
    @(negedge clk);
  endtask

  task automatic check(string tag);
    int idx;
    logic [3:0] an_e;
    logic [3:0] dig_e;
    idx   = (k / DIV) % 4;
    an_e  = 4'(1 << idx);
    dig_e = exp_digit(exp_val, idx);
    checks++;
    assert (busy === exp_busy) else begin
      failures++;
      $error("FAIL %s busy got=%b exp=%b", tag, busy, exp_busy);
    end
    checks++;
    assert (an === an_e) else begin
      failures++;
      $error("FAIL %s an got=%b exp=%b", tag, an, an_e);
    end
    checks++;
    assert (digit === dig_e) else begin
      failures++;
      $error("FAIL %s digit got=%h exp=%h", tag, digit, dig_e);
    end
  endtask

  // Pulse load with v; optionally pulse a second (ignored) load with v2 at cycle drop_at.
  task automatic do_load(int v, int drop_at, int v2, string tag);
    value = 14'(v);
    load  = 1'b1;
    exp_busy = 1'b1;
    tick();
    load = 1'b0;
    check(tag);
    for (int i = 1; i <= 14; i++) begin
      if (i == drop_at) begin
        value = 14'(v2);
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
      check(tag);
    end
    tick();
    exp_busy = 1'b0;
    exp_val  = clampv(v);
    check(tag);
    $display("load value=%0d shown=%0d", v, exp_val);
  endtask

  task automatic scan(int n, string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag);
    end
  endtask

  initial begin
    int rv;
    checks   = 0;
    failures = 0;
    k        = 0;
    exp_val  = 0;
    exp_busy = 1'b0;
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    @(negedge clk);
    tick();
    check("reset");
    // Reset has priority over a simultaneous load
    value = 14'd1234;
    load  = 1'b1;
    tick();
    load = 1'b0;
    check("rst_over_load");
    rst = 1'b0;
    scan(10, "idle_after_reset");

    do_load(1234, 0, 0, "v1234");
    scan(10, "scan1234");
    do_load(12000, 0, 0, "clamp12000");
    scan(8, "scan9999");
    do_load(0, 0, 0, "zero");
    scan(8, "scan0");
    do_load(9999, 0, 0, "v9999");
    scan(4, "scan9999b");
    do_load(10000, 0, 0, "clamp10000");
    scan(4, "scan10000");
    do_load(7, 0, 0, "v7");
    scan(8, "scan7");
    do_load(5678, 5, 1111, "drop");
    scan(8, "scan5678");
    do_load(50, 0, 0, "v50");
    scan(8, "scan50");

    // Reset mid-conversion aborts and clears the display
    value = 14'd4321;
    load  = 1'b1;
    exp_busy = 1'b1;
    tick();
    load = 1'b0;
    check("abort_start");
    for (int i = 1; i < 7; i++) begin
      tick();
      check("abort_conv");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_busy = 1'b0;
    exp_val  = 0;
    check("abort_reset");
    $display("reset mid-conversion of 4321");
    scan(3, "after_abort");
    do_load(4321, 0, 0, "reload4321");
    scan(8, "scan4321");

    for (int n = 0; n < 20; n++) begin
      rv = int'($urandom_range(0, 16383));
      do_load(rv, 0, 0, "random");
      scan(int'($urandom_range(1, 9)), "scan_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Upstream driver for the 7-segment decoder. Takes a 14-bit binary value, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto one 4-bit digit bus with a one-hot digit-select. The 4-bit `digit` output feeds the decoder's digit input. `an` drives the common pins of a 4-digit display.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected. Legal range is ≥1.
- `clk`  in  1  system clock. The block uses one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  14  binary value to display. Values above 9999 are clamped.
- `load`  in  1  single-cycle strobe. Captures `value` when the block is idle.
- `busy`  out  1  high while a conversion is in progress.
- `digit`  out  4  BCD nibble of the currently selected digit. 4'b1111 means blank.
- `an`  out  4  one-hot digit select. Bit 0 is units and bit 3 is thousands. Active-high.

## Operation
- FSM states are IDLE, CONV and COMMIT.
  - IDLE: when `load`=1, capture `min(value, 9999)` into the shift register, clear the BCD accumulator and the shift count, then go to CONV.
  - CONV: performs one double-dabble step per cycle:
    - add 3 to each BCD nibble ≥5;
    - then shift {bcd, bin} left by one.
    - After 14 steps (count 0..13), go to COMMIT.
  - COMMIT: copy the 16-bit BCD accumulator into the display register `disp[15:0]` in one cycle, then go to IDLE.
- The display register changes only in COMMIT. Digits never show a partial conversion.
- `load` is ignored in CONV and COMMIT. There is no queueing.
- `busy` = (state != IDLE).
- Scanner:
  - `rcnt` counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index `idx` advances 0→1→2→3→0.
  - `an` = 1<<idx.
  - `digit` = disp[4*idx+3 : 4*idx], subject to the blanking described under Configuration.
- Scanner and converter run independently. COMMIT does not reset `idx` or `rcnt`.
- Width rules:
  - The clamp compares against 14'd9999.
  - The BCD accumulator is 16 bits.
  - The add-3 correction is applied per nibble before each shift, including the first shift.

## Timing
- Reset values:
  - `busy`=0, `digit`=4'b0000, `an`=4'b0001;
  - `disp`=16'h0000, `idx`=0, `rcnt`=0, state IDLE.
- With the blanking macro enabled, the reset `digit` is still 4'b0000, because the units digit is never blanked.
- Latency:
  - `load` sampled at edge N sets `busy`=1 after edge N.
  - CONV runs on edges N+1..N+14.
  - COMMIT at edge N+15 updates `disp` and clears `busy`.
  - The next `load` is accepted at edge N+16.
- `digit` and `an` are registered (or purely derived from registers). They change together, glitch-free, on the wrap edge.
- `REFRESH_DIV`=1 advances `idx` every cycle.
- Reset asserted mid-conversion aborts it:
  - state IDLE, `disp` cleared to 0, `busy`=0 after that edge.
- Reset has priority over `load` on the same edge.

## Configuration
- Macro `BCD_SCAN_BLANK_LEADING_ZEROS_EN`.
- Defined: the COMMIT stage also computes a 4-bit blank mask.
  - Digit k (k=1..3) is blanked when it and all higher digits are 0.
  - Blanked digits output 4'b1111, which decodes to all segments off.
  - Digit 0 is never blanked, so value 0 shows "0".
- Undefined: no mask logic exists, and all four digits always show their BCD value, with leading zeros shown as 0.

## Test plan
1. Reset, then hold `load`=0 for 10 cycles → `busy`=0, `an`=0001, `digit`=0 throughout the first REFRESH_DIV cycles.
2. Drive REFRESH_DIV=2, `value`=1234 and pulse `load` → `busy` stays high for exactly 15 cycles, then the scan shows (`an`,`digit`) = (0001,4), (0010,3), (0100,2), (1000,1), with each pair held for 2 cycles.
3. `value`=12000 with a `load` pulse → the digits read 9,9,9,9. Then `value`=0 → the digits read 0,0,0,0.
4. Load 5678, then pulse `load` with 1111 at cycle +5 during `busy` → the display shows 5678 and the second load is dropped. `busy` stays high for exactly 15 cycles.
5. Load 4321, then assert `rst` at cycle +7 → `busy`=0, `disp`=0, and `an`=0001 on the next cycle. A fresh load then converts correctly.
6. Macro defined, `value`=7 → the digits read 7,F,F,F. With the macro defined, `value`=0 → 0,F,F,F. With the macro undefined, `value`=7 → 7,0,0,0.
